// File: rtl/multdiv_seq_pkg.sv
// Shared constants and FSM state type for the iterative multiply/divide unit.
package multdiv_seq_pkg;

  localparam int unsigned MdWidth = 32;
  localparam int unsigned MdIter  = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_addsub.sv
// Shared adder/subtractor used by both Booth accumulation and division trial-subtract.
module md_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// A start pulse in any state restarts; the result is registered on the final iteration.
module multdiv_seq
  import multdiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MdWidth,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg   = {1'b1, {(WIDTH - 1){1'b0}}};

  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc holds the Booth high word or the division remainder; low holds multiplier or quotient.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             qm1_q, qm1_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             exc_q, exc_d;

  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_sub;
  logic [WIDTH:0]   mul_top;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign mag_a = data_operandA[WIDTH-1] ? (-data_operandA) : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? (-data_operandB) : data_operandB;

  md_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    low_d   = low_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    qm1_d   = qm1_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    exc_d   = exc_q;
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    mul_top = '0;

    unique case (state_q)
      StMult: begin
        add_a = {acc_q[WIDTH-1], acc_q};
        case ({low_q[0], qm1_q})
          2'b01:   add_b = {opnd_q[WIDTH-1], opnd_q};
          2'b10: begin
            add_b   = {opnd_q[WIDTH-1], opnd_q};
            add_sub = 1'b1;
          end
          default: add_b = '0;
        endcase
        // Arithmetic shift of {hi, lo, q-1} using the widened sum as the new sign.
        acc_d = add_sum[WIDTH:1];
        low_d = {add_sum[0], low_q[WIDTH-1:1]};
        qm1_d = low_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StDone;
          mul_top = {acc_d, low_d[WIDTH-1]};
          res_d   = low_d;
          exc_d   = !((&mul_top) || !(|mul_top));
        end
      end
      StDiv: begin
        add_a   = {acc_q, low_q[WIDTH-1]};
        add_b   = {1'b0, opnd_q};
        add_sub = 1'b1;
        if (!add_sum[WIDTH]) begin
          acc_d = add_sum[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = add_a[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StDone;
          res_d   = dz_q ? '0 : (neg_q ? (-low_d) : low_d);
          exc_d   = dz_q || ovf_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A start in any state aborts the current operation.
    if (ctrl_MULT || ctrl_DIV) begin
      cnt_d = '0;
      acc_d = '0;
      qm1_d = 1'b0;
      res_d = '0;
      exc_d = 1'b0;
      if (ctrl_MULT) begin
        state_d = StMult;
        low_d   = data_operandB;
        opnd_d  = data_operandA;
      end else begin
        state_d = StDiv;
        low_d   = mag_a;
        opnd_d  = mag_b;
        neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_d    = (data_operandB == '0);
        ovf_d   = (data_operandA == MinNeg) && (data_operandB == '1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      qm1_q   <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      qm1_q   <= qm1_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == StDone);
  assign busy           = (state_q != StIdle);

endmodule
